// File: rtl/tile_map_server.sv
`timescale 1ns/1ps
// tile_map_server
//   Tile map store for a maze game. A MAP_W x MAP_H array of 3-bit sprite
//   codes with two ports: a game-logic read/write port (read-first, latency 1)
//   and an independent renderer read port (latency 1). After reset an
//   initialiser fills the map (walls on the border, dots inside), one entry
//   per cycle, while busy is high.
//
//   Optional feature macro: TILE_MAP_DOT_COUNT_EN
//     defined   : dots_left tracks the number of dot tiles, all_cleared is
//                 high when none remain (and the initialiser is idle).
//     undefined : dots_left and all_cleared are tied to 0.
//
//   Ports
//     clock, reset           rising-edge clock, synchronous active-high reset
//     map_x, map_y           game-logic address (column, row)
//     readwrite, write_data  1 = write write_data, 0 = read
//     sprite_out             registered game-logic read data
//     vga_x, vga_y           renderer address
//     vga_sprite             registered renderer read data
//     busy                   high while the initialiser runs
//     dots_left, all_cleared dot bookkeeping (see macro above)
module tile_map_server #(
  parameter int MAP_W = 32,
  parameter int MAP_H = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] map_x,
  input  logic [4:0] map_y,
  input  logic       readwrite,
  input  logic [2:0] write_data,
  output logic [2:0] sprite_out,
  input  logic [4:0] vga_x,
  input  logic [4:0] vga_y,
  output logic [2:0] vga_sprite,
  output logic       busy,
  output logic [9:0] dots_left,
  output logic       all_cleared
);

  localparam int         DEPTH    = MAP_W * MAP_H;
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] SPR_DOT  = 3'd1;
  localparam logic [2:0] SPR_WALL = 3'd3;
  localparam logic [4:0] X_LAST   = 5'(MAP_W - 1);
  localparam logic [4:0] Y_LAST   = 5'(MAP_H - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state_q, state_d;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] init_addr;
  logic [4:0]    init_x, init_y;
  logic          init_last;
  logic [2:0]    init_val;
  logic [AW-1:0] game_addr, vga_addr;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [2:0]    mem_wd;

  assign game_addr = AW'(int'(map_y) * MAP_W + int'(map_x));
  assign vga_addr  = AW'(int'(vga_y) * MAP_W + int'(vga_x));
  assign init_last = (init_addr == A_LAST);
  assign init_val  = (init_x == 5'd0 || init_x == X_LAST ||
                      init_y == 5'd0 || init_y == Y_LAST) ? SPR_WALL : SPR_DOT;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_INIT: begin
        busy = 1'b1;
        if (init_last) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Initialiser walks the map in address order; x/y are tracked alongside
  // the linear address so the border test needs no divider.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_addr <= '0;
      init_x    <= '0;
      init_y    <= '0;
    end else if (state_q == S_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (init_x == X_LAST) begin
        init_x <= '0;
        init_y <= init_y + 1'b1;
      end else begin
        init_x <= init_x + 1'b1;
      end
    end
  end

  // ---------------- storage ----------------
  // Single write port shared between the initialiser and game logic; game
  // writes are simply not selected while initialising.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = game_addr;
    mem_wd = write_data;
    if (!reset) begin
      if (state_q == S_INIT) begin
        mem_we = 1'b1;
        mem_wa = init_addr;
        mem_wd = init_val;
      end else if (readwrite) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Both read registers sample the array before this edge's write lands,
  // which gives read-first behaviour on either port.
  always_ff @(posedge clock) begin
    if (reset || state_q == S_INIT) begin
      sprite_out <= '0;
      vga_sprite <= '0;
    end else begin
      sprite_out <= mem[game_addr];
      vga_sprite <= mem[vga_addr];
    end
  end

  // ---------------- dot bookkeeping ----------------
`ifdef TILE_MAP_DOT_COUNT_EN
  logic [9:0] dot_cnt;
  logic       was_dot, is_dot;

  // Compare against the current contents so a held write is counted once.
  assign was_dot = (mem[game_addr] == SPR_DOT);
  assign is_dot  = (write_data == SPR_DOT);

  always_ff @(posedge clock) begin
    if (reset) begin
      dot_cnt <= '0;
    end else if (state_q == S_INIT) begin
      if (init_val == SPR_DOT && dot_cnt != 10'h3ff) dot_cnt <= dot_cnt + 1'b1;
    end else if (readwrite) begin
      if (!was_dot && is_dot && dot_cnt != 10'h3ff)     dot_cnt <= dot_cnt + 1'b1;
      else if (was_dot && !is_dot && dot_cnt != 10'h0) dot_cnt <= dot_cnt - 1'b1;
    end
  end

  assign dots_left   = dot_cnt;
  assign all_cleared = (dot_cnt == 10'h0) && (state_q == S_RUN);
`else
  assign dots_left   = '0;
  assign all_cleared = 1'b0;
`endif

endmodule

// File: tb/tb_tile_map_server.sv
`timescale 1ns/1ps
module tb_tile_map_server;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] map_x, map_y, vga_x, vga_y;
  logic       readwrite;
  logic [2:0] write_data;
  logic [2:0] sprite_out, vga_sprite;
  logic       busy, all_cleared;
  logic [9:0] dots_left;

  int checks = 0;
  int errors = 0;

  tile_map_server dut (
    .clock(clock), .reset(reset),
    .map_x(map_x), .map_y(map_y),
    .readwrite(readwrite), .write_data(write_data),
    .sprite_out(sprite_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_sprite(vga_sprite),
    .busy(busy), .dots_left(dots_left), .all_cleared(all_cleared)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_cell(input int x, input int y);
    return (x == 0 || x == 31 || y == 0 || y == 31) ? 3'd3 : 3'd1;
  endfunction

`ifdef TILE_MAP_DOT_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  // Counts negedge samples with busy high, starting at the negedge where
  // reset was just released. Also checks both read ports stay at 0.
  task automatic wait_init(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (sprite_out !== 3'd0) chk("init_sprite_out", sprite_out, 0);
      if (vga_sprite !== 3'd0) chk("init_vga_sprite", vga_sprite, 0);
      n++;
      @(negedge clock);
    end
  endtask

  task automatic rd(input int x, input int y, input logic [2:0] exp, input string tag);
    map_x = 5'(x); map_y = 5'(y); readwrite = 1'b0;
    @(negedge clock);
    chk(tag, sprite_out, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; map_x = 0; map_y = 0; vga_x = 0; vga_y = 0;
    readwrite = 1'b0; write_data = 0;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1);
    chk("rst_sprite_out", sprite_out, 0);
    chk("rst_vga_sprite", vga_sprite, 0);
    chk("rst_dots_left", dots_left, 0);
    chk("rst_all_cleared", all_cleared, 0);

    // init with a game write hammering (3,3) throughout; it must be ignored
    map_x = 5'd3; map_y = 5'd3; readwrite = 1'b1; write_data = 3'd5;
    vga_x = 5'd3; vga_y = 5'd3;
    reset = 1'b0;
    wait_init(n);
    readwrite = 1'b0;
    chk("init_len", n, 1024);
    chk("init_dots", dots_left, CNT ? 900 : 0);
    chk("init_all_cleared", all_cleared, 0);

    rd(3, 3, 3'd1, "ignored_init_write");
    rd(0, 0, 3'd3, "rd_0_0");
    rd(5, 5, 3'd1, "rd_5_5");
    rd(31, 17, 3'd3, "rd_31_17");

    // held write of 0 at (5,5): read-first, then idempotent
    map_x = 5'd5; map_y = 5'd5; readwrite = 1'b1; write_data = 3'd0;
    @(negedge clock); chk("wr_held_1", sprite_out, 1);
    @(negedge clock); chk("wr_held_2", sprite_out, 0);
    @(negedge clock); chk("wr_held_3", sprite_out, 0);
    readwrite = 1'b0;
    @(negedge clock); chk("wr_held_rd", sprite_out, 0);
    chk("wr_held_dots", dots_left, CNT ? 899 : 0);

    // store an unassigned code and get it back unchanged
    map_x = 5'd10; map_y = 5'd0; readwrite = 1'b1; write_data = 3'd6;
    @(negedge clock); chk("odd_code_pre", sprite_out, 3);
    readwrite = 1'b0;
    @(negedge clock); chk("odd_code_rd", sprite_out, 6);
    chk("odd_code_dots", dots_left, CNT ? 899 : 0);

    // same-cycle game write / renderer read at (7,9)
    map_x = 5'd7; map_y = 5'd9; vga_x = 5'd7; vga_y = 5'd9;
    readwrite = 1'b1; write_data = 3'd3;
    @(negedge clock); chk("vga_pre_write", vga_sprite, 1);
    readwrite = 1'b0;
    @(negedge clock); chk("vga_post_write", vga_sprite, 3);
    chk("vga_wr_dots", dots_left, CNT ? 898 : 0);

    // clear every interior cell
    readwrite = 1'b1; write_data = 3'd0;
    for (int y = 1; y <= 30; y++)
      for (int x = 1; x <= 30; x++) begin
        map_x = 5'(x); map_y = 5'(y);
        @(negedge clock);
      end
    readwrite = 1'b0;
    @(negedge clock);
    chk("clear_dots", dots_left, 0);
    chk("clear_all_cleared", all_cleared, CNT ? 1 : 0);

    map_x = 5'd1; map_y = 5'd1; readwrite = 1'b1; write_data = 3'd1;
    @(negedge clock);
    readwrite = 1'b0;
    @(negedge clock);
    chk("redot_dots", dots_left, CNT ? 1 : 0);
    chk("redot_all_cleared", all_cleared, 0);
    chk("redot_rd", sprite_out, 1);

    // reset mid-run, then reset again at init address 500
    reset = 1'b1;
    @(negedge clock);
    chk("rst2_busy", busy, 1);
    chk("rst2_dots", dots_left, 0);
    reset = 1'b0;
    repeat (500) @(negedge clock);
    chk("mid_init_busy", busy, 1);
    chk("mid_init_dots", dots_left, CNT ? 499 - 32 - 2 * 14 + 0 : 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst3_busy", busy, 1);
    chk("rst3_dots", dots_left, 0);
    reset = 1'b0;
    wait_init(n);
    chk("reinit_len", n, 1024);
    chk("reinit_dots", dots_left, CNT ? 900 : 0);

    // full map scan through the renderer port
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        vga_x = 5'(x); vga_y = 5'(y);
        @(negedge clock);
        chk($sformatf("map_%0d_%0d", x, y), vga_sprite, exp_cell(x, y));
      end
    rd(5, 5, 3'd1, "reinit_rd_5_5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
